// File: rtl/mips_pkg.sv
// Shared MIPS core types: instruction funct codes and the mul/div sequencer states.
package mips_pkg;

    typedef enum logic [5:0] {
        FN_MTHI  = 6'h11,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1A,
        FN_DIVU  = 6'h1B
    } funct_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_e;

    localparam logic [4:0] LAST_STEP = 5'd31;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself and is read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the core control path and the HI/LO mul/div unit.
interface mips_muldiv_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, funct, op_a, op_b, input busy, done, hi, lo);
    modport slave  (input start, funct, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module mips_div_step (
    input  logic [32:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic        quo_bit
);
    logic [33:0] shifted;
    logic [33:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {2'b00, divisor};
    assign quo_bit = ~diff[33];
    assign rem_out = quo_bit ? diff[32:0] : shifted[32:0];
endmodule

// File: rtl/mips_muldiv.sv
// Iterative 32-step multiply / restoring divide owning HI/LO; MTHI/MTLO write in one cycle.
module mips_muldiv
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mips_muldiv_if.slave  bus
);
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;   // mult: {partial product, multiplier}; div: [31:0] dividend -> quotient
    logic [32:0] rem_q, rem_d;
    logic [31:0] opb_q, opb_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        sign_a_q, sign_a_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_signed, sign_a, sign_b;
    logic [32:0] mul_sum;
    logic [32:0] step_rem;
    logic        step_q;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    mips_div_step u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (work_q[31]),
        .divisor      (opb_q),
        .rem_out      (step_rem),
        .quo_bit      (step_q)
    );

    assign is_signed = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
    assign sign_a    = is_signed & bus.op_a[31];
    assign sign_b    = is_signed & bus.op_b[31];
    assign mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
    assign prod_fix  = neg_q ? (~work_q + 64'd1) : work_q;
    // A zero divisor leaves an all-ones quotient that must not be sign-corrected.
    assign quo_fix   = (neg_q && (opb_q != 32'd0)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    assign rem_fix   = sign_a_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    // NOTE: every _d starts as its _q so no branch can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.funct)
                        FN_MTHI: begin
                            hi_d   = bus.op_a;
                            done_d = 1'b1;
                        end
                        FN_MTLO: begin
                            lo_d   = bus.op_a;
                            done_d = 1'b1;
                        end
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            work_d   = {32'd0, is_signed ? abs32(bus.op_a) : bus.op_a};
                            opb_d    = is_signed ? abs32(bus.op_b) : bus.op_b;
                            rem_d    = 33'd0;
                            is_div_d = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
                            sign_a_d = sign_a;
                            neg_d    = sign_a ^ sign_b;
                            cnt_d    = 5'd0;
                            state_d  = ST_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    rem_d  = step_rem;
                    work_d = {work_q[63:32], work_q[30:0], step_q};
                end else begin
                    work_d = {mul_sum, work_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments only; the reset is synchronous and
    // clears the datapath too, so an aborted operation leaves no stale partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            work_q   <= 64'd0;
            rem_q    <= 33'd0;
            opb_q    <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: expected HI/LO pairs are queued at issue and popped on done.
module tb_mips_muldiv;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    mips_muldiv_if bus ();

    mips_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        bus.start = 1'b1;
        bus.funct = fn;
        bus.op_a  = a;
        bus.op_b  = b;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        check({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " hi"}, bus.hi, e.hi);
            check({tag, " lo"}, bus.lo, e.lo);
        end
    endtask

    // Called on the first falling edge after the accepting edge; optionally pokes a DIVU mid-run.
    task automatic wait_done(input string tag, input bit poke);
        int busy_n = 0;
        int cyc    = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy === 1'b1) busy_n++;
            bus.start = poke && (cyc == 10);
            if (poke && cyc == 10) begin
                bus.funct = FN_DIVU;
                bus.op_a  = 32'h0000_0063;
                bus.op_b  = 32'h0000_0004;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        pop_cmp(tag);
    endtask

    task automatic done_drops(input string tag);
        @(negedge clk);
        check({tag, " done_pulse_width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.funct = 6'h00;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(FN_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_done("mult_neg", 1'b1);
        done_drops("mult_neg");

        issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done("multu_max", 1'b0);
        done_drops("multu_max");

        issue(FN_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        wait_done("mult_minmin", 1'b0);
        done_drops("mult_minmin");

        issue(FN_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_m7_2", 1'b0);
        // Chained start in the done cycle.
        issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        wait_done("div_ovf", 1'b0);
        done_drops("div_ovf");

        issue(FN_DIV, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
        wait_done("div_100_m7", 1'b0);
        done_drops("div_100_m7");

        issue(FN_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        wait_done("div_by0", 1'b0);
        done_drops("div_by0");

        issue(FN_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        wait_done("divu_by0", 1'b0);
        done_drops("divu_by0");

        issue(FN_MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        check("mthi done", {31'd0, bus.done}, 32'd1);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        pop_cmp("mthi");
        issue(FN_MTLO, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        check("mtlo done", {31'd0, bus.done}, 32'd1);
        check("mtlo busy", {31'd0, bus.busy}, 32'd0);
        pop_cmp("mtlo");
        done_drops("mtlo");

        bus.start = 1'b1;
        bus.funct = 6'h20;
        bus.op_a  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        check("bad_funct done", {31'd0, bus.done}, 32'd0);
        check("bad_funct busy", {31'd0, bus.busy}, 32'd0);
        check("bad_funct hi", bus.hi, 32'h1234_5678);
        check("bad_funct lo", bus.lo, 32'h9ABC_DEF0);

        issue(FN_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.funct = FN_DIVU;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("midrun busy", {31'd0, bus.busy}, 32'd1);
        repeat (9) @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.funct = FN_MTHI;
        bus.op_a  = 32'hDEAD_BEEF;
        @(negedge clk);
        sb.delete();
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        done_n    = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_n++;
        end
        check("abort no_late_done", 32'(done_n), 32'd0);
        check("abort hi_held", bus.hi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit owning the HI/LO register pair of the multicycle MIPS core. It sits directly downstream of the ALU source-B selector. It takes the same A and B operands the ALU sees (register A and the selected ALUB) on MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs a 32-step shift-add or restoring-divide sequence, and exposes HI/LO to the register-file write-back mux for MFHI/MFLO. The control FSM stalls on `busy`.

## Interface
Parameters:
- none; width is fixed at 32 bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; reset is synchronous and active-high on `clk`.
- `start`  in  1  request; sampled only when `busy`=0.
- `funct`  in  6  instruction funct field: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
- `op_a`  in  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- `op_b`  in  32  ALUB value: multiplier or divisor.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO are valid and updated.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM in IDLE, step counter 0.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 with MTHI → `hi`←`op_a`, `done`=1 next cycle, stay IDLE.
  - `start`=1 with MTLO → `lo`←`op_a`, `done`=1 next cycle, stay IDLE.
  - `start`=1 with mult/div funct → latch operands, go to CALC, counter←0.
  - Any other funct → ignored, no `done`.
- Operand latch:
  - Signed ops (MULT, DIV) latch |op_a| and |op_b| plus the two sign bits.
  - Unsigned ops latch the raw values.
  - |0x80000000| = 0x80000000, treated as unsigned.
- CALC: one step per cycle for exactly 32 cycles, then go to FIX.
  - Multiply: 64-bit shift-add, one multiplier bit per step, LSB first.
  - Divide: restoring, one quotient bit per step, MSB first.
- FIX (one cycle): apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
  - MULT: negate the 64-bit product (two's complement) if the operand signs differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
- Result placement:
  - Multiply: `hi`=product[63:32], `lo`=product[31:0].
  - Divide: `lo`=quotient, `hi`=remainder.
- Divide by zero (DIV or DIVU with `op_b`=0): still runs the full 33 cycles. Result is `hi`=`op_a` and `lo`=0xFFFFFFFF, with no sign fix-up.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- `hi`/`lo` hold their values at all times except on the FIX cycle or an MTHI/MTLO write.

## Timing
- Reference point: `start` accepted at edge N.
- Mult/div:
  - `busy`=1 after edges N … N+32, i.e. 33 cycles.
  - `hi`/`lo` updated at edge N+33, at which point `busy`=0 and `done`=1 for that one cycle.
- MTHI/MTLO: register updated at edge N, `done`=1 for the cycle after edge N, `busy` never set.
- `start` while `busy`=1: ignored, with no effect on the operands or the sequence.
- A new `start` in the same cycle `done` is high is accepted. `done` of the previous operation is unaffected.
- Changing `op_a`/`op_b` after edge N has no effect on the result.
- Reset asserted mid-operation: the next edge returns to reset values and the partial result is discarded.
- Reset together with `start`: reset wins.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg`: funct enum (MULT, MULTU, DIV, DIVU, MTHI, MTLO) and the FSM state enum. Add the funct enum there if not already present.
- Sub-module `mips_div_step`: combinational restoring-division step.
  - Inputs: partial remainder (33 bits), next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
- Multiply step stays inline in the top module.

## Test plan
- MULT: `op_a`=0xFFFFFFFE, `op_b`=3 → after 33 busy cycles, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, one `done` pulse.
- MULTU: `op_a`=`op_b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed divide:
  - DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 7 / 0 → `hi`=7, `lo`=0xFFFFFFFF, timing unchanged.
- MTHI 0x12345678, then next-cycle MTLO 0x9ABCDEF0 → each sets its register one cycle later with a `done` pulse, and neither raises `busy`.
- MULTU 5×6, then `start` DIVU at cycle 10 (ignored), then `reset` at cycle 20 → next edge gives `busy`=0, `hi`=`lo`=0, and no `done` pulse.
